// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds opcode constants, the FSM state encoding (4-bit, FETCH = 0) and the
// encodings of the alu_op, alu_src_b and pc_source mux selects. The ALU control
// and the datapath import the same package so both sides agree on encodings.
package mips_ctrl_pkg;

  // instr[31:26] opcodes
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtEx   = 4'd6,
    StRtWb   = 4'd7,
    StBeqEx  = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJEx    = 4'd11
  } state_e;

  // alu_op
  localparam logic [1:0] AluOpAdd   = 2'd0;
  localparam logic [1:0] AluOpSub   = 2'd1;
  localparam logic [1:0] AluOpFunct = 2'd2;

  // alu_src_b
  localparam logic [1:0] SrcBReg    = 2'd0;
  localparam logic [1:0] SrcBFour   = 2'd1;
  localparam logic [1:0] SrcBImm    = 2'd2;
  localparam logic [1:0] SrcBImmSh2 = 2'd3;

  // pc_source
  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OpR) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
           (op == OpAddi) || (op == OpJ);
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational state-to-control decoder for the multi-cycle MIPS FSM.
// Produces the raw (ungated) control word for a given state; the top level
// applies mem_ready and reset qualification to the write enables.
// Ports:
//   state_i        current FSM state (mips_ctrl_pkg::state_e encoding)
//   pc_write_o .. pc_source_o   raw datapath controls for that state
module mc_control_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o
);

  state_e state;
  assign state = state_e'(state_i);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SrcBReg;
    alu_op_o        = AluOpAdd;
    pc_source_o     = PcSrcAlu;

    unique case (state)
      StFetch: begin
        mem_read_o  = 1'b1;
        ir_write_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        pc_write_o  = 1'b1;
      end
      // Precompute the branch target into ALUOut while the opcode decodes.
      StDecode: alu_src_b_o = SrcBImmSh2;
      StMemAdr, StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      StMemWr: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StRtEx: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluOpFunct;
      end
      StRtWb: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      StAddiWb: reg_write_o = 1'b1;
      StBeqEx: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = AluOpSub;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PcSrcAluOut;
      end
      StJEx: begin
        pc_write_o  = 1'b1;
        pc_source_o = PcSrcJump;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back for a shared single-memory / single-ALU datapath.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   opcode          instr[31:26] from the IR (valid from DECODE onward)
//   zero            ALU zero flag (forwarded by the datapath, unused here)
//   mem_ready       memory access completes this cycle
//   pc_write .. pc_source   datapath write enables and mux selects
//   illegal_op      one-cycle pulse in DECODE on an undecodable opcode
//   state_o         current state for debug
// WAIT_MEM = 1 stalls FETCH/MEMRD/MEMWR until mem_ready; 0 ignores mem_ready.
module mc_control
  import mips_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  state_e dec_state;
  logic   mem_go;
  logic   fetch_hold;
  logic   unused_zero;

  logic raw_pc_write, raw_pc_write_cond, raw_mem_write, raw_ir_write, raw_reg_write;

  assign unused_zero = zero;
  assign mem_go      = (WAIT_MEM == 1'b0) || mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (mem_go) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StRtEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_go) state_d = StMemWb;
      StMemWr:  if (mem_go) state_d = StFetch;
      StRtEx:   state_d = StRtWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StRtWb, StAddiWb, StBeqEx, StJEx: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // While in reset the mux selects show their FETCH values; the register
  // itself still holds the abandoned state until the reset edge.
  assign dec_state = rst ? StFetch : state_q;

  mc_control_decode u_decode (
    .state_i         (dec_state),
    .pc_write_o      (raw_pc_write),
    .pc_write_cond_o (raw_pc_write_cond),
    .iord_o          (iord),
    .mem_read_o      (mem_read),
    .mem_write_o     (raw_mem_write),
    .ir_write_o      (raw_ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (raw_reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .pc_source_o     (pc_source)
  );

  // IR and PC load only on the fetch cycle whose read actually completes.
  assign fetch_hold = (dec_state == StFetch) && !mem_go;

  assign pc_write      = raw_pc_write & ~rst & ~fetch_hold;
  assign ir_write      = raw_ir_write & ~rst & ~fetch_hold;
  assign pc_write_cond = raw_pc_write_cond & ~rst;
  assign mem_write     = raw_mem_write & ~rst;
  assign reg_write     = raw_reg_write & ~rst;
  assign illegal_op    = ~rst && (state_q == StDecode) && !is_known_op(opcode);

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class cycle by cycle
// and compares state and the full control word against hand-built vectors.
module tb_mc_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;
  logic [16:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control #(.WAIT_MEM(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state_o       (state_o)
  );

  assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [16:0] mk(input logic pw, input logic pwc, input logic io,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rd, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] psrc,
                                     input logic ill);
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are set at the falling edge; sample 1 unit later, then move on.
  task automatic cyc(input string tag, input state_e st, input logic [16:0] c);
    #1;
    check_eq({tag, "/state"}, 32'(state_o), 32'(st));
    check_eq({tag, "/ctl"}, 32'(ctl), 32'(c));
    @(negedge clk);
  endtask

  logic [16:0] c_fetch, c_fwait, c_dec, c_dec_ill, c_memadr, c_memrd, c_memwr, c_memwb;
  logic [16:0] c_rtex, c_rtwb, c_addiwb, c_beq, c_jex;

  initial begin
    //             pw pwc io mr mw irw m2r rd rw asa asb   aop   psrc  ill
    c_fetch   = mk(1, 0,  0, 1, 0, 1,  0,  0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
    c_fwait   = mk(0, 0,  0, 1, 0, 0,  0,  0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
    c_dec     = mk(0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 2'd3, 2'd0, 2'd0, 0);
    c_dec_ill = mk(0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 2'd3, 2'd0, 2'd0, 1);
    c_memadr  = mk(0, 0,  0, 0, 0, 0,  0,  0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
    c_memrd   = mk(0, 0,  1, 1, 0, 0,  0,  0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    c_memwr   = mk(0, 0,  1, 0, 1, 0,  0,  0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    c_memwb   = mk(0, 0,  0, 0, 0, 0,  1,  0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
    c_rtex    = mk(0, 0,  0, 0, 0, 0,  0,  0, 0, 1, 2'd0, 2'd2, 2'd0, 0);
    c_rtwb    = mk(0, 0,  0, 0, 0, 0,  0,  1, 1, 0, 2'd0, 2'd0, 2'd0, 0);
    c_addiwb  = mk(0, 0,  0, 0, 0, 0,  0,  0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
    c_beq     = mk(0, 1,  0, 0, 0, 0,  0,  0, 0, 1, 2'd0, 2'd1, 2'd1, 0);
    c_jex     = mk(1, 0,  0, 0, 0, 0,  0,  0, 0, 0, 2'd0, 2'd0, 2'd2, 0);

    rst = 1'b1; mem_ready = 1'b1; opcode = OpLw; zero = 1'b0;
    @(negedge clk);
    cyc("rst0", StFetch, c_fwait);
    cyc("rst1", StFetch, c_fwait);
    rst = 1'b0;

    // LW, 5 cycles
    cyc("lw_f", StFetch, c_fetch);
    cyc("lw_d", StDecode, c_dec);
    cyc("lw_a", StMemAdr, c_memadr);
    cyc("lw_r", StMemRd, c_memrd);
    cyc("lw_w", StMemWb, c_memwb);

    // J, 3 cycles
    opcode = OpJ;
    cyc("j_f", StFetch, c_fetch);
    cyc("j_d", StDecode, c_dec);
    cyc("j_x", StJEx, c_jex);

    // BEQ, 3 cycles; zero toggled to show it has no effect
    opcode = OpBeq; zero = 1'b1;
    cyc("beq_f", StFetch, c_fetch);
    cyc("beq_d", StDecode, c_dec);
    cyc("beq_x", StBeqEx, c_beq);
    zero = 1'b0;

    // SW with 3 wait cycles in MEMWR
    opcode = OpSw;
    cyc("sw_f", StFetch, c_fetch);
    cyc("sw_d", StDecode, c_dec);
    cyc("sw_a", StMemAdr, c_memadr);
    mem_ready = 1'b0;
    cyc("sw_w0", StMemWr, c_memwr);
    cyc("sw_w1", StMemWr, c_memwr);
    cyc("sw_w2", StMemWr, c_memwr);
    mem_ready = 1'b1;
    cyc("sw_w3", StMemWr, c_memwr);

    // R-type with 2 fetch wait cycles; mem_ready low in RTEX is ignored
    opcode = OpR; mem_ready = 1'b0;
    cyc("r_fw0", StFetch, c_fwait);
    cyc("r_fw1", StFetch, c_fwait);
    mem_ready = 1'b1;
    cyc("r_f", StFetch, c_fetch);
    cyc("r_d", StDecode, c_dec);
    mem_ready = 1'b0;
    cyc("r_x", StRtEx, c_rtex);
    mem_ready = 1'b1;
    cyc("r_w", StRtWb, c_rtwb);

    // ADDI
    opcode = OpAddi;
    cyc("addi_f", StFetch, c_fetch);
    cyc("addi_d", StDecode, c_dec);
    cyc("addi_x", StAddiEx, c_memadr);
    cyc("addi_w", StAddiWb, c_addiwb);

    // Illegal opcode, 2 cycles
    opcode = 6'b111111;
    cyc("ill_f", StFetch, c_fetch);
    cyc("ill_d", StDecode, c_dec_ill);

    // LW with one MEMRD wait, then reset asserted in MEMRD
    opcode = OpLw;
    cyc("lwr_f", StFetch, c_fetch);
    cyc("lwr_d", StDecode, c_dec);
    cyc("lwr_a", StMemAdr, c_memadr);
    mem_ready = 1'b0;
    cyc("lwr_rw", StMemRd, c_memrd);
    mem_ready = 1'b1; rst = 1'b1;
    cyc("lwr_rst", StMemRd, c_fwait);
    rst = 1'b0;
    cyc("lwr_post", StFetch, c_fetch);
    cyc("lwr_post_d", StDecode, c_dec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
